// File: rtl/led_pkg.sv
// Shared alarm FSM states, LED field-offset helpers and prescaler sizing
// for the stopwatch front-panel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BLINK    = 2'd1,
    ST_SILENCED = 2'd2
  } alarm_state_e;

  function automatic int alarm_width(input int n_alarm);
    return n_alarm;
  endfunction

  function automatic int enable_idx(input int n_alarm);
    return n_alarm;
  endfunction

  function automatic int state_msb_idx(input int n_state, input int n_alarm);
    return n_state + n_alarm;
  endfunction

  function automatic int prescaler_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

  localparam int DEF_N_STATE_LED   = 2;
  localparam int DEF_N_ALARM_LED   = 5;
  localparam int DEF_STATE_MSB_IDX = state_msb_idx(DEF_N_STATE_LED, DEF_N_ALARM_LED);
  localparam int DEF_ENABLE_IDX    = enable_idx(DEF_N_ALARM_LED);
  localparam int DEF_ALARM_WIDTH   = alarm_width(DEF_N_ALARM_LED);

endpackage

// File: rtl/led_status_driver_prescaler.sv
// Blink prescaler: counts 0..BLINK_DIV-1 while enabled, one-cycle tick on the last count.
// Tick is combinational from the count register; clr dominates en. No backpressure.
module blink_prescaler
  import led_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = prescaler_width(BLINK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_status_driver.sv
// Stopwatch LED bank: one-hot mode LEDs, alarm-enable mirror, blinking alarm field
// with ack/auto-silence. 1-cycle registered latency, no backpressure; LED_CHASE_EN adds chase mode.
module led_status_driver
  import led_pkg::*;
#(
  parameter int N_STATE_LED       = DEF_N_STATE_LED,
  parameter int N_ALARM_LED       = DEF_N_ALARM_LED,
  parameter int BLINK_DIV         = 25_000_000,
  parameter int ALARM_MAX_TOGGLES = 120
) (
  input  logic                               Clk,
  input  logic                               Rst_n,
  input  logic [$clog2(N_STATE_LED+1)-1:0]   STATE,
  input  logic                               AL_switch,
  input  logic                               AL_ON,
  input  logic                               AL_ACK,
`ifdef LED_CHASE_EN
  input  logic                               CHASE,
`endif
  output logic [N_STATE_LED+N_ALARM_LED:0]   LED,
  output logic                               AL_SILENCED
);

  localparam int SW     = $clog2(N_STATE_LED + 1);
  localparam int AW     = alarm_width(N_ALARM_LED);
  localparam int EN_IDX = enable_idx(N_ALARM_LED);
  localparam int S_MSB  = state_msb_idx(N_STATE_LED, N_ALARM_LED);
  localparam int TW     = $clog2(ALARM_MAX_TOGGLES + 2);
  localparam logic [TW-1:0] TOG_MAX = TW'(ALARM_MAX_TOGGLES);

  typedef logic [N_STATE_LED-1:0] state_field_t;
  typedef logic [AW-1:0]          alarm_field_t;

  alarm_state_e  st_q, st_nxt;
  state_field_t  state_q, state_nxt;
  alarm_field_t  alarm_q, alarm_nxt;
  logic          en_q, phase_q, phase_nxt, silenced_q;
  logic          tick, pre_clr, auto_sil;
  logic [TW-1:0] tog_q, tog_nxt, tog_inc;

`ifdef LED_CHASE_EN
  localparam alarm_field_t POS_MSB = alarm_field_t'(1) << (AW - 1);
  logic         chase_q, chase_nxt;
  alarm_field_t pos_q, pos_nxt;
`endif

  // Counter restarts on every BLINK entry so a re-armed alarm gets a full first period.
  assign pre_clr = (st_q != ST_BLINK) || (st_nxt != ST_BLINK);

  blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_prescaler (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (pre_clr),
    .en    (st_q == ST_BLINK),
    .tick  (tick)
  );

  assign tog_inc  = (&tog_q) ? tog_q : tog_q + 1'b1;
  assign auto_sil = (ALARM_MAX_TOGGLES != 0) && (tog_inc == TOG_MAX);

  always_comb begin
    state_nxt = state_q;
    if (STATE == '0) begin
      state_nxt = '0;
    end else begin
      for (int k = 1; k <= N_STATE_LED; k++) begin
        if (STATE == SW'(k)) state_nxt = state_field_t'(1) << (N_STATE_LED - k);
      end
    end
  end

  always_comb begin
    st_nxt    = st_q;
    phase_nxt = phase_q;
    tog_nxt   = tog_q;
`ifdef LED_CHASE_EN
    chase_nxt = chase_q;
    pos_nxt   = pos_q;
`endif
    case (st_q)
      ST_IDLE: begin
        tog_nxt   = '0;
        phase_nxt = 1'b0;
        if (AL_ON) begin
          st_nxt    = ST_BLINK;
          phase_nxt = 1'b1;
`ifdef LED_CHASE_EN
          chase_nxt = CHASE;
          pos_nxt   = POS_MSB;
`endif
        end
      end
      ST_BLINK: begin
        if (!AL_ON) begin
          st_nxt    = ST_IDLE;
          tog_nxt   = '0;
          phase_nxt = 1'b0;
        end else if (AL_ACK) begin
          st_nxt    = ST_SILENCED;
          phase_nxt = 1'b0;
        end else if (tick) begin
          tog_nxt   = tog_inc;
          phase_nxt = ~phase_q;
`ifdef LED_CHASE_EN
          chase_nxt = CHASE;
          pos_nxt   = (pos_q >> 1) | (pos_q << (AW - 1));
`endif
          if (auto_sil) begin
            st_nxt    = ST_SILENCED;
            phase_nxt = 1'b0;
          end
        end
      end
      ST_SILENCED: begin
        if (!AL_ON) begin
          st_nxt  = ST_IDLE;
          tog_nxt = '0;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase

    alarm_nxt = '0;
    if (st_nxt == ST_BLINK) begin
`ifdef LED_CHASE_EN
      alarm_nxt = chase_nxt ? pos_nxt : {AW{phase_nxt}};
`else
      alarm_nxt = {AW{phase_nxt}};
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q       <= ST_IDLE;
      state_q    <= '0;
      en_q       <= 1'b0;
      alarm_q    <= '0;
      phase_q    <= 1'b0;
      tog_q      <= '0;
      silenced_q <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      state_q    <= state_nxt;
      en_q       <= AL_switch;
      alarm_q    <= alarm_nxt;
      phase_q    <= phase_nxt;
      tog_q      <= tog_nxt;
      silenced_q <= (st_nxt == ST_SILENCED);
    end
  end

`ifdef LED_CHASE_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      chase_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      chase_q <= chase_nxt;
      pos_q   <= pos_nxt;
    end
  end
`endif

  assign LED[S_MSB -: N_STATE_LED] = state_q;
  assign LED[EN_IDX]               = en_q;
  assign LED[AW-1:0]               = alarm_q;
  assign AL_SILENCED               = silenced_q;

endmodule

// File: tb/tb_led_status_driver.sv
// Scoreboard bench for led_status_driver: directed stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_led_status_driver;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] mask;
    logic [7:0] led;
    logic       sil;
    string      tag;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] STATE;
  logic       AL_switch, AL_ON, AL_ACK;
  logic [7:0] led1, led2;
  logic       sil1, sil2;
  logic       al_on2, chase;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       sb[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  led_status_driver #(
    .N_STATE_LED(2), .N_ALARM_LED(5), .BLINK_DIV(4), .ALARM_MAX_TOGGLES(3)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .STATE(STATE), .AL_switch(AL_switch),
    .AL_ON(AL_ON), .AL_ACK(AL_ACK),
`ifdef LED_CHASE_EN
    .CHASE(1'b0),
`endif
    .LED(led1), .AL_SILENCED(sil1)
  );

`ifdef LED_CHASE_EN
  led_status_driver #(
    .N_STATE_LED(2), .N_ALARM_LED(5), .BLINK_DIV(2), .ALARM_MAX_TOGGLES(0)
  ) dut_chase (
    .Clk(Clk), .Rst_n(Rst_n), .STATE(2'b00), .AL_switch(1'b0),
    .AL_ON(al_on2), .AL_ACK(1'b0), .CHASE(chase),
    .LED(led2), .AL_SILENCED(sil2)
  );
`else
  assign led2 = '0;
  assign sil2 = 1'b0;
`endif

  task automatic expect_at(input int c, input int d, input logic [7:0] m,
                           input logic [7:0] l, input logic s, input string t);
    exp_t e;
    e.cyc = c; e.dut = d; e.mask = m; e.led = l; e.sil = s; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Monitor: compares every expectation due at this cycle.
  always @(negedge Clk) begin
    exp_t       e;
    logic [7:0] a_led;
    logic       a_sil;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e     = sb.pop_front();
      a_led = (e.dut == 0) ? led1 : led2;
      a_sil = (e.dut == 0) ? sil1 : sil2;
      n_cmp++;
      if (e.cyc != cyc || (a_led & e.mask) != e.led || a_sil != e.sil) begin
        n_bad++;
        $display("FAIL %s @cycle %0d (due %0d): LED=%b AL_SILENCED=%b, expected LED&%b=%b AL_SILENCED=%b",
                 e.tag, cyc, e.cyc, a_led, a_sil, e.mask, e.led, e.sil);
      end
    end
  end

  initial begin
    exp_t e;
    Rst_n = 1'b0; STATE = 2'd0; AL_switch = 1'b0; AL_ON = 1'b0; AL_ACK = 1'b0;
    al_on2 = 1'b0; chase = 1'b0;
    expect_at(1, 0, 8'hFF, 8'h00, 1'b0, "reset_state");

    goto(2);  Rst_n = 1'b1;
    goto(3);  STATE = 2'd1;
    expect_at(3, 0, 8'hFF, 8'h00, 1'b0, "idle_after_release");
    expect_at(4, 0, 8'hC0, 8'h80, 1'b0, "state1");
    goto(4);  STATE = 2'd2;
    expect_at(5, 0, 8'hC0, 8'h40, 1'b0, "state2");
    goto(5);  STATE = 2'd3;
    expect_at(6, 0, 8'hC0, 8'h40, 1'b0, "state3_holds");
    goto(6);  STATE = 2'd0; AL_switch = 1'b1;
    expect_at(7, 0, 8'hE0, 8'h20, 1'b0, "state0_enable_led");

    goto(7);
    n_cmp++;
    if (led1[7:5] !== 3'b001) begin
        n_bad++;
        $display("FAIL direct_enable_led: LED=%b", led1);
    end

    goto(10); AL_ON = 1'b1;
    expect_at(11, 0, 8'h1F, 8'h1F, 1'b0, "blink_entry_on");
    expect_at(14, 0, 8'h1F, 8'h1F, 1'b0, "blink_first_half");
    expect_at(15, 0, 8'h1F, 8'h00, 1'b0, "blink_first_off");
    expect_at(19, 0, 8'h1F, 8'h1F, 1'b0, "blink_second_on");
    expect_at(22, 0, 8'h1F, 8'h1F, 1'b0, "blink_before_auto");
    expect_at(23, 0, 8'h1F, 8'h00, 1'b1, "auto_silence");
    expect_at(27, 0, 8'h1F, 8'h00, 1'b1, "silenced_holds");

    goto(11);
    n_cmp++;
    if (led1[4:0] !== 5'h1F) begin
        n_bad++;
        $display("FAIL direct_blink_entry: LED=%b", led1);
    end
    goto(15);
    n_cmp++;
    if (led1[4:0] !== 5'h00) begin
        n_bad++;
        $display("FAIL direct_blink_off: LED=%b", led1);
    end
    goto(23);
    n_cmp++;
    if (sil1 !== 1'b1 || led1[4:0] !== 5'h00) begin
        n_bad++;
        $display("FAIL direct_auto_silence: LED=%b AL_SILENCED=%b", led1, sil1);
    end

    goto(28); AL_ON = 1'b0;
    expect_at(29, 0, 8'h1F, 8'h00, 1'b0, "silenced_to_idle");
    goto(30); AL_ON = 1'b1;
    expect_at(31, 0, 8'h1F, 8'h1F, 1'b0, "restart_on");
    expect_at(34, 0, 8'h1F, 8'h1F, 1'b0, "restart_half");
    expect_at(35, 0, 8'h1F, 8'h00, 1'b0, "restart_off");

    goto(36); AL_ON = 1'b0; AL_ACK = 1'b1;
    expect_at(37, 0, 8'h1F, 8'h00, 1'b0, "ack_and_off_same_cycle");
    expect_at(38, 0, 8'h1F, 8'h00, 1'b0, "ack_and_off_stays_idle");
    goto(37); AL_ACK = 1'b0;
    goto(40); AL_ON = 1'b1;
    expect_at(41, 0, 8'h1F, 8'h1F, 1'b0, "rearm_on");
    goto(42); AL_ACK = 1'b1;
    expect_at(43, 0, 8'h1F, 8'h00, 1'b1, "ack_silences");
    expect_at(46, 0, 8'h1F, 8'h00, 1'b1, "ack_silence_holds");
    goto(43); AL_ACK = 1'b0;
    n_cmp++;
    if (sil1 !== 1'b1) begin
        n_bad++;
        $display("FAIL direct_ack_silence: AL_SILENCED=%b", sil1);
    end
    goto(48); AL_ON = 1'b0;
    expect_at(49, 0, 8'h1F, 8'h00, 1'b0, "ack_silence_cleared");

    goto(52); AL_ON = 1'b1;
    expect_at(53, 0, 8'h1F, 8'h1F, 1'b0, "midperiod_on");
    goto(54); AL_ON = 1'b0;
    expect_at(55, 0, 8'h1F, 8'h00, 1'b0, "midperiod_drop");
    goto(55); AL_ON = 1'b1;
    expect_at(56, 0, 8'h1F, 8'h1F, 1'b0, "midperiod_reentry");
    expect_at(59, 0, 8'h1F, 8'h1F, 1'b0, "no_carry_over");
    expect_at(60, 0, 8'h1F, 8'h00, 1'b0, "fresh_period_off");
    expect_at(63, 0, 8'h1F, 8'h00, 1'b0, "fresh_period_off_end");
    expect_at(64, 0, 8'h1F, 8'h1F, 1'b0, "lit_before_reset");

    goto(65); #1; Rst_n = 1'b0;
    expect_at(65, 0, 8'hFF, 8'h00, 1'b0, "async_reset_immediate");
    expect_at(66, 0, 8'hFF, 8'h00, 1'b0, "reset_held");
    goto(67); Rst_n = 1'b1;
    expect_at(67, 0, 8'hFF, 8'h00, 1'b0, "reset_just_released");
    expect_at(68, 0, 8'hFF, 8'h3F, 1'b0, "post_reset_blink");

`ifdef LED_CHASE_EN
    goto(70); al_on2 = 1'b1; chase = 1'b1;
    expect_at(71, 1, 8'h1F, 8'h10, 1'b0, "chase_entry");
    expect_at(72, 1, 8'h1F, 8'h10, 1'b0, "chase_hold");
    expect_at(73, 1, 8'h1F, 8'h08, 1'b0, "chase_tick1");
    expect_at(75, 1, 8'h1F, 8'h04, 1'b0, "chase_tick2");
    expect_at(77, 1, 8'h1F, 8'h02, 1'b0, "chase_tick3");
    expect_at(79, 1, 8'h1F, 8'h01, 1'b0, "chase_tick4");
    expect_at(81, 1, 8'h1F, 8'h10, 1'b0, "chase_wrap");
`endif

    goto(90);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation for cycle %0d was never checked", e.tag, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule

// File: doc/led_status_driver.md
# led_status_driver

Parametrised successor to the stopwatch front-panel LED driver. Decodes the stopwatch mode into one-hot state LEDs and mirrors the alarm-enable switch. Drives a bank of alarm LEDs from an internal prescaler rather than a derived slow clock, with acknowledge and auto-silence. Sits between the control state machine / alarm comparator and the board LED pins.

## Interface
- `N_STATE_LED`, 2: number of state-indicator LEDs.
- `N_ALARM_LED`, 5: number of alarm LEDs.
- `BLINK_DIV`, 25_000_000: Clk cycles per alarm half-period (2 Hz blink at 100 MHz); minimum 2.
- `ALARM_MAX_TOGGLES`, 120: toggles before auto-silence; 0 = never.
- `Clk`  in  1  system clock; one clock domain, all logic on posedge.
- `Rst_n`  in  1  reset, asynchronous, active-low.
- `STATE`  in  $clog2(N_STATE_LED+1)  mode from the control state machine.
- `AL_switch`  in  1  alarm-enable switch level.
- `AL_ON`  in  1  alarm-active level from the comparator.
- `AL_ACK`  in  1  single-cycle silence request (push-button, already debounced).
- `LED`  out  N_STATE_LED+1+N_ALARM_LED  LED bank, fields MSB→LSB: state LEDs, enable LED, alarm LEDs.
- `AL_SILENCED`  out  1  high while FSM is in SILENCED.

## Operation
- State field: STATE=0 lights none. STATE=k (1..N_STATE_LED) lights exactly one LED, k=1 at the field MSB (top bit of LED). Out-of-range STATE holds the previous field value. Registered.
- Enable LED = AL_switch, registered.
- Alarm FSM states: IDLE, BLINK, SILENCED.
  - IDLE: alarm field all 0; prescaler and toggle count held at 0. AL_ON=1 → BLINK with phase=1.
  - BLINK: the prescaler counts 0..BLINK_DIV-1 and wraps. At count BLINK_DIV-1 a tick occurs: phase inverts and the toggle count increments (saturating). Alarm field is all-ones when phase=1, else 0.
    - AL_ACK=1 → SILENCED.
    - A tick that makes the count equal ALARM_MAX_TOGGLES (when nonzero) → SILENCED.
  - SILENCED: alarm field 0. Remains until AL_ON=0.
  - Any state, AL_ON=0 → IDLE; counters cleared.
- Priority on the same cycle: AL_ON=0 > AL_ACK > auto-silence > tick. AL_ACK outside BLINK is ignored.

## Timing
- Reset (Rst_n low): LED=0, AL_SILENCED=0, FSM=IDLE, prescaler=0, toggle count=0, phase=0. Takes effect immediately; release is synchronous to Clk.
- All outputs are registered: 1-cycle latency from an input change to LED.
- AL_ON rising at cycle n: alarm field all-ones at n+1. First toggle off at n+1+BLINK_DIV, then every BLINK_DIV cycles.
- AL_ON falling, or AL_ACK in BLINK, at cycle n: alarm field 0 at n+1. AL_SILENCED follows the FSM with the same latency.
- With default parameters, auto-silence occurs 120·BLINK_DIV cycles after BLINK entry, with the field off.
- AL_ON toggling mid-period restarts the phase from scratch; there is no partial-period carry-over.

## Configuration
- `LED_CHASE_EN` defined: adds input `CHASE` (1 bit), which is sampled at each tick and on BLINK entry.
  - CHASE=1: the alarm field is one-hot. It starts at the field MSB on entry and shifts one position toward the LSB per tick, wrapping LSB→MSB. Phase is unused.
  - CHASE=0: all-flash behaviour as above.
- `LED_CHASE_EN` undefined: no `CHASE` port; all-flash only. Toggle counting is identical in both builds.

## Structure
- Package `led_pkg` holds:
  - the alarm FSM state enum (IDLE, BLINK, SILENCED);
  - localparam helpers for field offsets (state MSB index, enable index, alarm field width);
  - the prescaler width function.
- Sub-module `blink_prescaler`: counter with clear and enable, emitting a 1-cycle `tick` at BLINK_DIV-1. The FSM, decode and LED register stay in the top level.

## Test plan
- Reset asserted mid-BLINK with field lit → LED=0 immediately; AL_ON held 1 after release → field all-ones 1 cycle later.
- STATE sequence 0,1,2,3 (defaults) → LED[7:6] = 00, 10, 01, 01 (the value 3 holds the previous pattern); AL_switch=1 → LED[5]=1 next cycle.
- BLINK_DIV=4, AL_ON rises at cycle 10 → LED[4:0]=11111 at cycle 11, 00000 at 15, 11111 at 19.
- BLINK_DIV=4, ALARM_MAX_TOGGLES=3, AL_ON held → SILENCED after the 3rd tick, LED[4:0]=0, AL_SILENCED=1; AL_ON low then high → blinking restarts.
- AL_ACK and AL_ON falling on the same cycle → IDLE, AL_SILENCED stays 0. AL_ACK alone in BLINK → SILENCED, field 0 next cycle.
- With `LED_CHASE_EN`, CHASE=1, BLINK_DIV=2 → LED[4:0] = 10000, 01000, 00100, 00010, 00001, 10000 on successive ticks.
